// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: FIFO-buffered operand feeder running N-pair dot-product jobs on a MAC core
module mac_operand_sequencer #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_valid,
  input  logic [15:0]                    push_a,
  input  logic [15:0]                    push_b,
  output logic                           push_ready,
  input  logic [LEN_W-1:0]               cfg_len,
  input  logic                           cfg_go,
  input  logic                           abort,
  input  logic                           done_clr,
  output logic                           mac_clear,
  output logic                           mac_start,
  output logic [15:0]                    mac_a,
  output logic [15:0]                    mac_b,
  input  logic                           mac_busy,
  input  logic                           mac_ack,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
  output logic [LEN_W-1:0]               remaining,
  output logic                           run_busy,
  output logic                           run_done,
  output logic                           irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, WAIT} state_t;
  state_t state, state_nxt;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic abort_run, push_ok, pop, go, go_run, ack_ok, last;
  assign push_ready = fifo_count < CW'(DEPTH);
  assign abort_run = abort && state != IDLE;
  assign push_ok = push_valid && push_ready && !abort;
  assign pop = state == ISSUE && fifo_count != '0 && !mac_busy && !abort;
  assign go = state == IDLE && cfg_go;
  assign go_run = go && cfg_len != '0;
  assign ack_ok = state == WAIT && mac_ack && !abort;
  assign last = ack_ok && remaining == LEN_W'(1);
  assign mac_clear = state == CLEAR;
  assign run_busy = state != IDLE;
  assign irq = run_done;
  always_comb begin
    state_nxt = abort_run ? IDLE :
                go_run ? CLEAR :
                state == CLEAR ? ISSUE :
                pop ? WAIT :
                ack_ok ? (last ? IDLE : ISSUE) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_a, push_b};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      remaining  <= '0;
      mac_a      <= '0;
      mac_b      <= '0;
      mac_start  <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      wr_ptr     <= abort ? '0 : wr_ptr + AW'(push_ok);
      rd_ptr     <= abort ? '0 : rd_ptr + AW'(pop);
      fifo_count <= abort ? '0 : fifo_count + CW'(push_ok) - CW'(pop);
      remaining  <= abort_run ? '0 : go_run ? cfg_len : ack_ok ? remaining - LEN_W'(1) : remaining;
      mac_start  <= pop;
      if (pop) {mac_a, mac_b} <= mem[rd_ptr];
      run_done   <= (last || (go && cfg_len == '0)) ? 1'b1 : (done_clr || go) ? 1'b0 : run_done;
    end
  end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed self-checking bench for mac_operand_sequencer
module tb_mac_operand_sequencer;
  logic clk = 1'b0;
  logic rst, push_valid, cfg_go, abort, done_clr, mac_busy, mac_ack;
  logic [15:0] push_a, push_b, mac_a, mac_b;
  logic [7:0] cfg_len, remaining;
  logic [3:0] fifo_count;
  logic push_ready, mac_clear, mac_start, run_busy, run_done, irq;
  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_clear = 0;
  int s0, c0;
  mac_operand_sequencer #(.DEPTH(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_a(push_a), .push_b(push_b),
    .push_ready(push_ready), .cfg_len(cfg_len), .cfg_go(cfg_go), .abort(abort),
    .done_clr(done_clr), .mac_clear(mac_clear), .mac_start(mac_start), .mac_a(mac_a),
    .mac_b(mac_b), .mac_busy(mac_busy), .mac_ack(mac_ack), .fifo_count(fifo_count),
    .remaining(remaining), .run_busy(run_busy), .run_done(run_done), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mac_start === 1'b1) n_start <= n_start + 1;
    if (mac_clear === 1'b1) n_clear <= n_clear + 1;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [15:0] a, input logic [15:0] b);
    push_a = a;
    push_b = b;
    push_valid = 1'b1;
    tick();
    push_valid = 1'b0;
  endtask
  task automatic wait_start();
    for (int i = 0; i < 20 && mac_start !== 1'b1; i++) tick();
    chk("mac_start_seen", {31'b0, mac_start}, 1);
  endtask
  task automatic do_mac(input logic [15:0] ea, input logic [15:0] eb);
    wait_start();
    chk("mac_a", {16'b0, mac_a}, {16'b0, ea});
    chk("mac_b", {16'b0, mac_b}, {16'b0, eb});
    tick();
    chk("start_pulse_width", {31'b0, mac_start}, 0);
    mac_ack = 1'b1;
    tick();
    mac_ack = 1'b0;
  endtask
  initial begin
    rst = 1'b1; push_valid = 1'b0; push_a = '0; push_b = '0; cfg_len = '0; cfg_go = 1'b0;
    abort = 1'b0; done_clr = 1'b0; mac_busy = 1'b0; mac_ack = 1'b0;
    tick();
    tick();
    chk("rst_fifo_count", {28'b0, fifo_count}, 0);
    chk("rst_remaining", {24'b0, remaining}, 0);
    chk("rst_push_ready", {31'b0, push_ready}, 1);
    chk("rst_run_done", {31'b0, run_done}, 0);
    chk("rst_mac_start", {31'b0, mac_start}, 0);
    chk("rst_mac_clear", {31'b0, mac_clear}, 0);
    chk("rst_mac_a", {16'b0, mac_a}, 0);
    chk("rst_run_busy", {31'b0, run_busy}, 0);
    rst = 1'b0;
    s0 = n_start; c0 = n_clear;
    push(16'd3, 16'd4);
    push(16'hFFFE, 16'd5);
    push(16'd7, 16'd7);
    chk("t1_count", {28'b0, fifo_count}, 3);
    cfg_len = 8'd3; cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    chk("t1_clear", {31'b0, mac_clear}, 1);
    chk("t1_rem3", {24'b0, remaining}, 3);
    chk("t1_busy", {31'b0, run_busy}, 1);
    tick();
    chk("t1_clear_once", {31'b0, mac_clear}, 0);
    do_mac(16'd3, 16'd4);
    chk("t1_rem2", {24'b0, remaining}, 2);
    do_mac(16'hFFFE, 16'd5);
    chk("t1_rem1", {24'b0, remaining}, 1);
    chk("t1_not_done", {31'b0, run_done}, 0);
    do_mac(16'd7, 16'd7);
    chk("t1_rem0", {24'b0, remaining}, 0);
    chk("t1_done", {31'b0, run_done}, 1);
    chk("t1_irq", {31'b0, irq}, 1);
    chk("t1_idle", {31'b0, run_busy}, 0);
    chk("t1_nstart", n_start - s0, 3);
    chk("t1_nclear", n_clear - c0, 1);
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
    chk("t2_done_clr", {31'b0, run_done}, 0);
    s0 = n_start; c0 = n_clear;
    cfg_len = 8'd0; cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    chk("t2_done", {31'b0, run_done}, 1);
    chk("t2_idle", {31'b0, run_busy}, 0);
    tick();
    chk("t2_no_clear", n_clear - c0, 0);
    chk("t2_no_start", n_start - s0, 0);
    chk("t2_rem", {24'b0, remaining}, 0);
    for (int i = 0; i < 9; i++) begin
      push(16'(256 + i), 16'(512 + i));
      if (i == 7) chk("t3_full_ready", {31'b0, push_ready}, 0);
    end
    chk("t3_count8", {28'b0, fifo_count}, 8);
    chk("t3_ready0", {31'b0, push_ready}, 0);
    cfg_len = 8'd8; cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    chk("t3_go_clears_done", {31'b0, run_done}, 0);
    for (int i = 0; i < 8; i++) do_mac(16'(256 + i), 16'(512 + i));
    chk("t3_done", {31'b0, run_done}, 1);
    chk("t3_empty", {28'b0, fifo_count}, 0);
    cfg_len = 8'd2; cfg_go = 1'b1; mac_busy = 1'b1;
    tick();
    cfg_go = 1'b0;
    tick();
    push(16'h1111, 16'h2222);
    s0 = n_start;
    repeat (3) tick();
    chk("t4_busy_hold", n_start - s0, 0);
    chk("t4_count1", {28'b0, fifo_count}, 1);
    mac_busy = 1'b0;
    tick();
    chk("t4_start_after_busy", {31'b0, mac_start}, 1);
    chk("t4_a", {16'b0, mac_a}, 32'h1111);
    tick();
    mac_ack = 1'b1;
    tick();
    mac_ack = 1'b0;
    chk("t4_rem1", {24'b0, remaining}, 1);
    repeat (3) tick();
    chk("t4_starve", n_start - s0, 1);
    chk("t4_still_busy", {31'b0, run_busy}, 1);
    push(16'h3333, 16'h4444);
    do_mac(16'h3333, 16'h4444);
    chk("t4_done", {31'b0, run_done}, 1);
    for (int i = 0; i < 4; i++) push(16'(16 + i), 16'(32 + i));
    cfg_len = 8'd4; cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    do_mac(16'd16, 16'd32);
    do_mac(16'd17, 16'd33);
    chk("t5_count2", {28'b0, fifo_count}, 2);
    chk("t5_rem2", {24'b0, remaining}, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    s0 = n_start;
    chk("t5_idle", {31'b0, run_busy}, 0);
    chk("t5_flush", {28'b0, fifo_count}, 0);
    chk("t5_rem0", {24'b0, remaining}, 0);
    chk("t5_done0", {31'b0, run_done}, 0);
    chk("t5_no_start", {31'b0, mac_start}, 0);
    mac_ack = 1'b1;
    tick();
    mac_ack = 1'b0;
    repeat (2) tick();
    chk("t5_late_ack_start", n_start - s0, 0);
    chk("t5_late_ack_rem", {24'b0, remaining}, 0);
    chk("t5_late_ack_done", {31'b0, run_done}, 0);
    push(16'h55, 16'h66);
    push(16'h77, 16'h88);
    push(16'h99, 16'hAA);
    cfg_len = 8'd2; cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    wait_start();
    chk("t6_in_job", {31'b0, run_busy}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_count", {28'b0, fifo_count}, 0);
    chk("t6_rem", {24'b0, remaining}, 0);
    chk("t6_start", {31'b0, mac_start}, 0);
    chk("t6_a", {16'b0, mac_a}, 0);
    chk("t6_b", {16'b0, mac_b}, 0);
    chk("t6_busy", {31'b0, run_busy}, 0);
    chk("t6_ready", {31'b0, push_ready}, 1);
    chk("t6_done", {31'b0, run_done}, 0);
    push(16'd9, 16'd10);
    cfg_len = 8'd1; cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    wait_start();
    chk("t6_new_a", {16'b0, mac_a}, 9);
    chk("t6_new_b", {16'b0, mac_b}, 10);
    tick();
    mac_ack = 1'b1; done_clr = 1'b1;
    tick();
    mac_ack = 1'b0; done_clr = 1'b0;
    chk("t6_done_wins", {31'b0, run_done}, 1);
    chk("t6_irq", {31'b0, irq}, 1);
    tick();
    chk("t6_done_sticky", {31'b0, run_done}, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
